adc_serial_capture: RTL

//  Parametrised successor to the single-channel CNV/SCK/SDO pulse generator.

---
 rtl/adc_serial_capture.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/adc_serial_capture.sv
// Multi-channel serial ADC capture: shared CNV/SCK, one SDO per channel, MSB-first.
// All channel words are presented together through a valid/ready handshake.
module adc_serial_capture #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SCK_DIV = 2,
    parameter int unsigned T_CONV  = 150,
    parameter int unsigned PERIOD  = 420
) (
    input  logic                     clk210_p,
    input  logic                     reset_n_p,
    input  logic                     enable_p,
    input  logic                     trig_mode_p,
    input  logic                     trig_p,
    input  logic [N_CH-1:0]          sdo_p,
    output logic                     cnv_p,
    output logic                     sck_p,
    output logic [N_CH*DATA_W-1:0]   sample_data_p,
    output logic                     sample_valid_p,
    input  logic                     sample_ready_p,
    output logic                     overrun_p,
    input  logic                     clear_ovr_p,
    output logic                     busy_p
);

    localparam int unsigned PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned TW  = (T_CONV > 1) ? $clog2(T_CONV) : 1;
    localparam int unsigned HW  = $clog2(2 * SCK_DIV);
    localparam int unsigned BW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StConv  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]                   state_q, state_d;
    logic [PW-1:0]                per_cnt_q, per_cnt_d;
    logic [TW-1:0]                conv_cnt_q, conv_cnt_d;
    logic [HW-1:0]                ph_q, ph_d;
    logic [BW-1:0]                bit_q, bit_d;
    logic [N_CH-1:0][DATA_W-1:0]  shreg_q, shreg_d;
    logic                         cnv_q, cnv_d;
    logic                         sck_q, sck_d;
    logic [N_CH*DATA_W-1:0]       data_q, data_d;
    logic                         valid_q, valid_d;
    logic                         ovr_q, ovr_d;
    logic                         start;

    assign start = enable_p && (trig_mode_p ? trig_p : (per_cnt_q == PW'(PERIOD - 1)));

    always_comb begin
        state_d    = state_q;
        conv_cnt_d = conv_cnt_q;
        ph_d       = ph_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        cnv_d      = cnv_q;
        sck_d      = sck_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;

        // Counter free-runs regardless of FSM state so the start grid stays fixed.
        if (enable_p && !trig_mode_p) begin
            per_cnt_d = (per_cnt_q == PW'(PERIOD - 1)) ? '0 : per_cnt_q + 1'b1;
        end else begin
            per_cnt_d = '0;
        end

        if (valid_q && sample_ready_p) valid_d = 1'b0;
        if (clear_ovr_p) ovr_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StConv;
                    cnv_d      = 1'b1;
                    conv_cnt_d = '0;
                end
            end
            StConv: begin
                if (conv_cnt_q == TW'(T_CONV - 1)) begin
                    state_d = StShift;
                    cnv_d   = 1'b0;
                    ph_d    = '0;
                    bit_d   = '0;
                end else begin
                    conv_cnt_d = conv_cnt_q + 1'b1;
                end
            end
            StShift: begin
                if (ph_q == HW'(2 * SCK_DIV - 1)) begin
                    sck_d = 1'b0;
                    ph_d  = '0;
                    if (bit_q == BW'(DATA_W - 1)) state_d = StDone;
                    else                          bit_d   = bit_q + 1'b1;
                end else begin
                    ph_d = ph_q + 1'b1;
                    // Sample on the same edge that raises SCK.
                    if (ph_q == HW'(SCK_DIV - 1)) begin
                        sck_d = 1'b1;
                        for (int i = 0; i < N_CH; i++) begin
                            shreg_d[i] = {shreg_q[i][DATA_W-2:0], sdo_p[i]};
                        end
                    end
                end
            end
            default: begin
                data_d  = shreg_q;
                valid_d = 1'b1;
                if (valid_q && !sample_ready_p) ovr_d = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk210_p or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q    <= StIdle;
            per_cnt_q  <= '0;
            conv_cnt_q <= '0;
            ph_q       <= '0;
            bit_q      <= '0;
            shreg_q    <= '0;
            cnv_q      <= 1'b0;
            sck_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            per_cnt_q  <= per_cnt_d;
            conv_cnt_q <= conv_cnt_d;
            ph_q       <= ph_d;
            bit_q      <= bit_d;
            shreg_q    <= shreg_d;
            cnv_q      <= cnv_d;
            sck_q      <= sck_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign cnv_p          = cnv_q;
    assign sck_p          = sck_q;
    assign sample_data_p  = data_q;
    assign sample_valid_p = valid_q;
    assign overrun_p      = ovr_q;
    assign busy_p         = (state_q != StIdle);

endmodule
